// File: rtl/piso_serializer_if.sv
// Load handshake and serial output bundle for the PISO serializer.
interface piso_serializer_if #(
  parameter int WIDTH = 8
);
  logic [WIDTH-1:0] p_in;
  logic             load_valid;
  logic             load_ready;
  logic             s_out;
  logic             s_valid;
  logic             s_last;
  logic             busy;

  // Serializer side: takes the word, drives the serial stream.
  modport slave (
    input  p_in, load_valid,
    output load_ready, s_out, s_valid, s_last, busy
  );

  // Producer side: offers words, observes the serial stream.
  modport master (
    output p_in, load_valid,
    input  load_ready, s_out, s_valid, s_last, busy
  );
endinterface

// File: rtl/piso_serializer.sv
// Parallel-in serial-out transmitter with valid/ready load and framing
// strobes. A word can be reloaded on its own last-bit cycle so frames
// stream back to back with no idle gap.
module piso_serializer #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  piso_serializer_if.slave  bus
);
  localparam int             CW   = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [CW-1:0]    cnt_q, cnt_d;

  logic             last_bit;
  logic             ready;
  logic             accept;
  logic [WIDTH-1:0] shreg_shifted;

  // Word is only replaceable when idle or on its final bit; reset blocks loads.
  assign last_bit = (state_q == SHIFT) && (cnt_q == LAST);
  assign ready    = !rst && ((state_q == IDLE) || last_bit);
  assign accept   = bus.load_valid && ready;

  // Move the register one place toward whichever end feeds s_out.
  assign shreg_shifted = MSB_FIRST ? {shreg_q[WIDTH-2:0], 1'b0}
                                   : {1'b0, shreg_q[WIDTH-1:1]};

  // State, shift register and bit counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      shreg_q <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state logic and framing outputs.
  always_comb begin
    state_d        = state_q;
    shreg_d        = shreg_q;
    cnt_d          = cnt_q;
    bus.load_ready = ready;
    bus.s_valid    = 1'b0;
    bus.s_out      = 1'b0;
    bus.s_last     = 1'b0;
    bus.busy       = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          shreg_d = bus.p_in;
          cnt_d   = '0;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        bus.s_valid = 1'b1;
        bus.busy    = 1'b1;
        bus.s_out   = MSB_FIRST ? shreg_q[WIDTH-1] : shreg_q[0];
        bus.s_last  = last_bit;
        if (last_bit) begin
          if (accept) begin
            shreg_d = bus.p_in;
            cnt_d   = '0;
          end else begin
            // Hold cnt at its ceiling; it only wraps on a reload.
            shreg_d = shreg_shifted;
            state_d = IDLE;
          end
        end else begin
          shreg_d = shreg_shifted;
          cnt_d   = cnt_q + CW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end
endmodule

// File: tb/tb_piso_serializer.sv
// Scoreboard bench: two serializers (MSB-first and LSB-first) share one
// stimulus stream. Accepted words are expanded into expected bit queues
// by a behavioural model; a monitor compares the serial outputs.
module tb_piso_serializer;
  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic [W-1:0] p_in;
  logic         load_valid;

  int checks = 0;
  int errors = 0;
  bit mon_en = 1'b0;

  // Expected {bit, last} per serial cycle; index 0 = MSB-first, 1 = LSB-first.
  logic [1:0] q [2][$];

  piso_serializer_if #(.WIDTH(W)) if_m ();
  piso_serializer_if #(.WIDTH(W)) if_l ();

  assign if_m.p_in       = p_in;
  assign if_m.load_valid = load_valid;
  assign if_l.p_in       = p_in;
  assign if_l.load_valid = load_valid;

  piso_serializer #(.WIDTH(W), .MSB_FIRST(1'b1)) u_msb (
    .clk (clk), .rst (rst), .bus (if_m.slave)
  );
  piso_serializer #(.WIDTH(W), .MSB_FIRST(1'b0)) u_lsb (
    .clk (clk), .rst (rst), .bus (if_l.slave)
  );

  always #5 clk = ~clk;

  // Reference model: an idle transmitter (nothing left to send after the
  // bit now on the wire) accepts; an accepted word becomes W expected bits.
  always @(posedge clk) begin
    mon_en <= 1'b1;
    if (rst) begin
      q[0].delete();
      q[1].delete();
    end else if (load_valid && q[0].size() == 0) begin
      for (int k = 0; k < W; k++) begin
        q[0].push_back({p_in[W-1-k], k == W-1});
        q[1].push_back({p_in[k],     k == W-1});
      end
    end
  end

  // Monitor: compare outputs mid-cycle against the model's queues.
  always @(negedge clk) begin
    if (mon_en) begin
      for (int i = 0; i < 2; i++) begin
        logic       sv, so, sl, lr, bz, exp_rdy;
        logic [1:0] e;
        string      nm;
        nm = (i == 0) ? "msb" : "lsb";
        sv = (i == 0) ? if_m.s_valid    : if_l.s_valid;
        so = (i == 0) ? if_m.s_out      : if_l.s_out;
        sl = (i == 0) ? if_m.s_last     : if_l.s_last;
        lr = (i == 0) ? if_m.load_ready : if_l.load_ready;
        bz = (i == 0) ? if_m.busy       : if_l.busy;
        exp_rdy = !rst && (q[i].size() <= 1);
        checks++;
        if (lr !== exp_rdy) begin
          errors++;
          $display("FAIL %s load_ready t=%0t got %b want %b", nm, $time, lr, exp_rdy);
        end
        checks++;
        if (sv !== (q[i].size() != 0) || bz !== (q[i].size() != 0)) begin
          errors++;
          $display("FAIL %s s_valid/busy t=%0t got %b/%b want %b", nm, $time, sv, bz,
                   q[i].size() != 0);
        end
        if (q[i].size() != 0) begin
          e = q[i].pop_front();
          checks++;
          if (so !== e[1] || sl !== e[0]) begin
            errors++;
            $display("FAIL %s bit t=%0t got out=%b last=%b want out=%b last=%b",
                     nm, $time, so, sl, e[1], e[0]);
          end
        end else begin
          checks++;
          if (so !== 1'b0 || sl !== 1'b0) begin
            errors++;
            $display("FAIL %s idle_out t=%0t got out=%b last=%b want 0/0", nm, $time, so, sl);
          end
        end
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drive(input logic r, input logic v, input logic [W-1:0] d, input int n);
    rst = r; load_valid = v; p_in = d;
    cyc(n);
  endtask

  initial begin
    rst = 1'b1; load_valid = 1'b1; p_in = 8'hFF;
    // Reset held with a pending load: nothing may be accepted.
    cyc(2);
    drive(0, 0, 8'h00, 3);
    // Single word.
    drive(0, 1, 8'b10110011, 1);
    drive(0, 0, 8'h00, 11);
    // Back-to-back: second word held through the busy window.
    drive(0, 1, 8'hA5, 1);
    drive(0, 1, 8'h3C, 8);
    drive(0, 0, 8'h00, 10);
    // Loads while busy are ignored, then accepted on the last-bit edge.
    drive(0, 1, 8'hF0, 1);
    drive(0, 0, 8'h00, 1);
    drive(0, 1, 8'h0F, 7);
    drive(0, 0, 8'h00, 10);
    // Reset mid-frame, then a fresh word.
    drive(0, 1, 8'hFF, 1);
    drive(0, 0, 8'h00, 3);
    drive(1, 0, 8'h00, 1);
    drive(0, 1, 8'h81, 1);
    drive(0, 0, 8'h00, 10);
    // Random traffic with occasional resets.
    for (int c = 0; c < 3000; c++) begin
      rst        = ($urandom_range(0, 149) == 0);
      load_valid = ($urandom_range(0, 3) != 0);
      p_in       = W'($urandom);
      cyc(1);
    end
    drive(0, 0, 8'h00, W + 4);
    checks++;
    if (q[0].size() != 0 || q[1].size() != 0) begin
      errors++;
      $display("FAIL drain pending got %0d/%0d want 0/0", q[0].size(), q[1].size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/piso_serializer.md
# piso_serializer

Parallel-in serial-out transmitter. It accepts a WIDTH-bit word through a valid/ready load handshake and shifts it out one bit per clock on `s_out`, with framing strobes. It is the transmit end of the team's serial shift-register link and drives the serial input of the SIPO receiver. Back-to-back words stream with no idle gap between them.

## Interface
- `WIDTH`, default 8: word width in bits; minimum 2.
- `MSB_FIRST`, default 1: 1 sends bit WIDTH-1 first; 0 sends bit 0 first.

- `clk`, input, 1: single clock; all state updates on the rising edge.
- `rst`, input, 1: synchronous, active-high reset.
- `p_in`, input, WIDTH: parallel word, sampled only on an accepted load.
- `load_valid`, input, 1: `p_in` holds a word to send.
- `load_ready`, output, 1: block can accept a word this cycle.
- `s_out`, output, 1: serial data bit.
- `s_valid`, output, 1: `s_out` carries a valid bit this cycle.
- `s_last`, output, 1: high with the final bit of each word.
- `busy`, output, 1: a word is in flight (state SHIFT).

## Operation
- Registers:
  - `state` ∈ {IDLE, SHIFT}
  - `shreg[WIDTH-1:0]`
  - `cnt[$clog2(WIDTH)-1:0]`
- Accept condition: `load_valid && load_ready` at a rising edge.
- IDLE:
  - `load_ready`=1, `s_valid`=0, `s_out`=0, `s_last`=0, `busy`=0.
  - On accept: `shreg`←`p_in`, `cnt`←0, go to SHIFT.
- SHIFT:
  - `s_valid`=1, `busy`=1.
  - `s_out` = `shreg[WIDTH-1]` if `MSB_FIRST`, else `shreg[0]`.
  - Each edge: shift `shreg` one position toward the output end (zero fill) and increment `cnt`.
- Last bit (`cnt`==WIDTH-1):
  - `s_last`=1 and `load_ready`=1.
  - On accept: `shreg`←`p_in`, `cnt`←0, stay in SHIFT. This gives a seamless back-to-back stream.
  - No accept: go to IDLE.
- Before the last bit (`cnt`<WIDTH-1): `load_ready`=0. `load_valid` and `p_in` are ignored and cannot corrupt the word in flight.
- `s_out` is forced to 0 whenever `s_valid`=0.
- `load_ready` is combinational from `state`, `cnt` and `rst`.
- `load_ready` is forced to 0 while `rst`=1.
- `cnt` never exceeds WIDTH-1 and wraps to 0 only on reload.

## Timing
- Reset, when `rst`=1 at an edge:
  - `state`←IDLE, `shreg`←0, `cnt`←0.
  - From the following cycle: `s_out`=0, `s_valid`=0, `s_last`=0, `busy`=0, `load_ready`=1 (after `rst` deasserts).
  - Reset has priority over load.
- Latency: word accepted at edge N. Bit k (k=0..WIDTH-1, in send order) is on `s_out` during the cycle after edge N+k. `s_last` is high in the cycle after edge N+WIDTH-1.
- Throughput: one word per WIDTH cycles when `load_valid` is held high.
- Idle gap: zero cycles between words when reloaded on the last-bit cycle. Otherwise at least one `s_valid`=0 cycle.
- Reset mid-frame: the partial word is discarded with no further bits sent. `s_valid` is 0 in the cycle after the reset edge.
- `load_valid` held high with `rst`=1: no accept occurs. The first accept is at the first edge with `rst`=0.
- WIDTH=2 boundary: `s_last` on the 2nd bit, and the reload window lasts one cycle.

## Test plan
- Reset values:
  - Hold `rst`=1 for 2 cycles with `load_valid`=1 and `p_in`=8'hFF.
  - Required: `s_valid`=0, `s_out`=0, `busy`=0, `load_ready`=0 during reset.
  - Required: `load_ready`=1 and no bits sent before the first post-reset accept.
- Single word, MSB first:
  - Load 8'b10110011.
  - Required: `s_out` = 1,0,1,1,0,0,1,1 on 8 consecutive `s_valid` cycles, `s_last` on the 8th only, then IDLE with `s_valid`=0.
- LSB first (`MSB_FIRST`=0):
  - Load 8'b10110011.
  - Required: `s_out` = 1,1,0,0,1,1,0,1, `s_last` on the 8th.
- Back-to-back:
  - Hold `load_valid`=1 with 8'hA5 then 8'h3C, changing `p_in` on each accept.
  - Required: 16 contiguous `s_valid` cycles carrying 10100101 then 00111100, and `s_last` on cycles 8 and 16.
- Ignored load while busy:
  - After loading 8'hF0, set `p_in`=8'h0F with `load_valid`=1 during bits 1–6.
  - Required: output stays 11110000 and `load_ready`=0 until the last bit. The 8'h0F word is accepted on the last-bit edge and follows with no gap.
- Reset mid-frame:
  - Load 8'hFF and assert `rst` for 1 cycle after 3 bits.
  - Required: `s_valid`=0 in the cycle after the reset edge. A following load of 8'h81 sends exactly 10000001.
